// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC and issues one in-order word
// request at a time to a variable-latency instruction memory. Returned words
// go into a small circular queue whose head feeds decode. A taken branch
// flushes the queue and marks any in-flight response for discard.
module if_fetch_stage #(
    parameter int ADDRESS_LEN = 32,
    parameter int QUEUE_DEPTH = 2     // 2..4 entries
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_valid,
    input  logic [ADDRESS_LEN-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [ADDRESS_LEN-1:0] instruction,
    output logic [ADDRESS_LEN-1:0] pc
);

    // Pointer and occupancy widths sized for the 2..4 entry range.
    localparam int PTR_W = (QUEUE_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [PTR_W-1:0]       LAST_PTR   = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [CNT_W:0]         DEPTH_CNT  = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [ADDRESS_LEN-1:0] WORD_BYTES = ADDRESS_LEN'(4);

    // Architectural fetch state.
    logic [ADDRESS_LEN-1:0] fetch_pc_reg;
    logic [ADDRESS_LEN-1:0] req_addr_reg;      // address of the request in flight
    logic                   outstanding_reg;   // one request awaiting its response
    logic                   discard_reg;       // in-flight response belongs to a flushed path

    // Queue bookkeeping.
    logic [PTR_W-1:0]       head_reg;
    logic [PTR_W-1:0]       tail_reg;
    logic [CNT_W-1:0]       count_reg;

    // Queue storage: per entry, the fetch address + 4 and the fetched word.
    logic [ADDRESS_LEN-1:0] entry_pc_reg   [QUEUE_DEPTH];
    logic [ADDRESS_LEN-1:0] entry_word_reg [QUEUE_DEPTH];

    // Per-cycle decisions.
    logic                   resp_live;
    logic                   push;
    logic                   pop;
    logic                   issue;
    logic [CNT_W:0]         occ_next;
    logic [ADDRESS_LEN-1:0] fetch_pc_next;
    logic [ADDRESS_LEN-1:0] push_pc;
    logic [PTR_W-1:0]       head_next;
    logic [PTR_W-1:0]       tail_next;

    // Circular increment that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_PTR) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    assign if_valid = (count_reg != '0);

    // Consume/produce/issue decisions; a redirect suppresses all three.
    always_comb begin
        resp_live     = imem_valid && outstanding_reg;
        pop           = if_valid && !freeze && !branch_taken;
        push          = resp_live && !discard_reg && !branch_taken;
        occ_next      = {1'b0, count_reg} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
        // A new request may go out only when the previous one is retiring this
        // cycle (or none is pending) and a slot is still free for its response
        // after this cycle's push and pop.
        issue         = !rst && !branch_taken
                        && (!outstanding_reg || imem_valid)
                        && (occ_next < DEPTH_CNT);
        fetch_pc_next = fetch_pc_reg + WORD_BYTES;
        push_pc       = req_addr_reg + WORD_BYTES;
        head_next     = pop  ? ptr_inc(head_reg) : head_reg;
        tail_next     = push ? ptr_inc(tail_reg) : tail_reg;
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_reg;

    // Head of the queue drives decode; zeroed when no live instruction.
    always_comb begin
        instruction = '0;
        pc          = '0;
        if (if_valid) begin
            instruction = entry_word_reg[head_reg];
            pc          = entry_pc_reg[head_reg];
        end
    end

    // Fetch PC, request tracking and queue pointers; redirect wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= '0;
            req_addr_reg    <= '0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else if (branch_taken) begin
            fetch_pc_reg    <= branch_address;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            // A response landing this very cycle retires the request outright;
            // otherwise the one still in flight must be dropped when it lands.
            outstanding_reg <= outstanding_reg && !imem_valid;
            discard_reg     <= outstanding_reg && !imem_valid;
        end else begin
            if (issue) begin
                fetch_pc_reg <= fetch_pc_next;
                req_addr_reg <= fetch_pc_reg;
            end
            if (issue) begin
                outstanding_reg <= 1'b1;
            end else if (resp_live) begin
                outstanding_reg <= 1'b0;
            end
            if (resp_live) begin
                discard_reg <= 1'b0;
            end
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= occ_next[CNT_W-1:0];
        end
    end

    // Queue storage: each entry captures the returning word when it is the tail.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PTR_W'(gi))) begin
                    entry_pc_reg[gi]   <= push_pc;
                    entry_word_reg[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage sitting directly upstream of the decode stage. It owns the architectural fetch PC and issues in-order word requests to an external instruction memory with variable response latency. Returned words are buffered in a small fetch queue whose head drives the decode stage's `instruction` / `pc_in` inputs. Taken-branch redirects from execute flush the queue, and the decode-side freeze (hazard or multi-cycle stall) holds the head.

## Interface
- `ADDRESS_LEN`, 32, width of PC, addresses and instruction words
- `QUEUE_DEPTH`, 2, fetch queue entries; legal range 2..4
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `freeze`  in  1  decode cannot accept this cycle (Hazard | cycle_freeze)
- `branch_taken`  in  1  one-cycle redirect pulse from execute
- `branch_address`  in  ADDRESS_LEN  redirect target, word aligned
- `imem_req`  out  1  request strobe, one cycle per request
- `imem_addr`  out  ADDRESS_LEN  request address, valid while `imem_req`=1
- `imem_valid`  in  1  response strobe, in request order
- `imem_rdata`  in  ADDRESS_LEN  response word, valid while `imem_valid`=1
- `if_valid`  out  1  queue head holds a live instruction
- `instruction`  out  ADDRESS_LEN  head instruction; 0 when `if_valid`=0
- `pc`  out  ADDRESS_LEN  head fetch address + 4; 0 when `if_valid`=0

## Operation
- State: `fetch_pc`; queue of {addr+4, word} with head/tail pointers and `count`; `outstanding` (0/1); `discard` (0/1).
- At most one memory request outstanding at any time.
- Pop: `if_valid`=1 and `freeze`=0 and `branch_taken`=0 → head consumed at the clock edge.
- Push: `imem_valid`=1 and `outstanding`=1 and `discard`=0 and `branch_taken`=0 → word written at tail with pc = request addr + 4. The request address is latched at issue.
- Issue: `imem_req`=1 when `branch_taken`=0 and (`outstanding`=0 or `imem_valid`=1) and (count + push − pop) < QUEUE_DEPTH. `imem_addr`=`fetch_pc`; `fetch_pc` += 4 on issue. Issue is combinational from current-cycle state and inputs.
- The queue never overflows; a response always has a free slot reserved at issue.
- Redirect (`branch_taken`=1): count←0, `fetch_pc`←`branch_address`, no issue, no push, no pop this cycle.
  - If a request is still in flight and `imem_valid`=0 that cycle, set `discard`←1.
  - The next response is then dropped and clears `discard` and `outstanding`.
  - Redirect has priority over freeze, push and pop.
- `imem_valid` with `outstanding`=0 (stale, e.g. after reset) is ignored.
- `fetch_pc` arithmetic is modulo 2^ADDRESS_LEN; 0xFFFFFFFC + 4 wraps to 0.
- `pc` wraps the same way.

## Timing
- Reset values: `fetch_pc`=0, count=0, `outstanding`=0, `discard`=0, `imem_req`=0 during reset, `if_valid`=0, `instruction`=0, `pc`=0.
- First request (addr 0) is issued in the first cycle with `rst`=0.
- With a 1-cycle memory (response the cycle after the request), the word is visible at `instruction`/`if_valid` one cycle after the response.
- Fetch-to-decode latency = memory latency + 1 cycle.
- Throughput with a 1-cycle memory is one instruction per cycle sustained; issue and response overlap in the same cycle.
- Full queue and `freeze`=1: no issue.
- Full queue and `freeze`=0: issue allowed in the same cycle, since the pop frees a slot.
- After a redirect, the first request to `branch_address` issues the next cycle, or later if a discarded response is still pending.
- `rst` mid-operation clears all state in that edge; in-flight responses are ignored.

## Test plan
- Reset release, 1-cycle memory returning word = addr ^ 0xE0000000, `freeze`=0:
  - `imem_addr` sequence 0,4,8,…, one per cycle.
  - `if_valid` rises 2 cycles after the first request.
  - `instruction` = 0xE0000000, 0xE0000004, …, `pc` = 4, 8, ….
- `freeze` held 5 cycles mid-stream:
  - head and `pc` stable throughout.
  - `imem_req` stops once count=2.
  - no instruction lost or duplicated after release.
- 3-cycle memory latency: `imem_req` spaced 3 cycles apart; `if_valid` pulses once per 3 cycles with correct addresses.
- `branch_taken` to 0x100 while a request is in flight (3-cycle memory):
  - queue empties next cycle (`if_valid`=0).
  - in-flight response dropped; next `imem_addr`=0x100.
  - first post-branch `pc`=0x104.
- `branch_taken` coincident with `imem_valid` and `freeze`=1: response dropped, no discard pending, request to target issued next cycle.
- `rst` asserted mid-stream with a response arriving the next cycle: all outputs 0, stale response ignored, first request afterwards to addr 0.
